// File: rtl/pool_job_sequencer.sv
// Job controller feeding the shapool hasher pool from a small job queue.
// Optional: POOL_JOB_SEQ_SKIP_EXHAUSTED_EN drops exhausted jobs without a report.
module pool_job_sequencer #(
   parameter int JOB_WIDTH        = 360,
   parameter int RESULT_WIDTH     = 32,
   parameter int QUEUE_DEPTH      = 2,
   parameter int QUEUE_DEPTH_LOG2 = 1,
   parameter int RUN_LIMIT_WIDTH  = 31
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [JOB_WIDTH-1:0]        job_in,
   input  logic                        job_valid_in,
   output logic                        job_ready_out,
   input  logic                        flush_in,
   output logic [JOB_WIDTH-1:0]        pool_job_out,
   output logic                        pool_reset_n_out,
   input  logic                        pool_success_in,
   input  logic [RESULT_WIDTH-1:0]     pool_nonce_in,
   output logic [RESULT_WIDTH-1:0]     result_out,
   output logic                        result_valid_out,
   input  logic                        result_ack_in,
   output logic                        exhausted_out,
   output logic                        busy_out,
   output logic [QUEUE_DEPTH_LOG2:0]   queue_count_out
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_RUN,
      S_REPORT
   } state_t;

   localparam logic [QUEUE_DEPTH_LOG2:0] DEPTH_C =
      (QUEUE_DEPTH_LOG2+1)'(QUEUE_DEPTH);

   state_t                       state_q, state_d;
   logic [JOB_WIDTH-1:0]         mem_q [QUEUE_DEPTH];
   logic [JOB_WIDTH-1:0]         mem_d [QUEUE_DEPTH];
   logic [QUEUE_DEPTH_LOG2-1:0]  head_q, head_d;
   logic [QUEUE_DEPTH_LOG2-1:0]  tail_q, tail_d;
   logic [QUEUE_DEPTH_LOG2:0]    count_q, count_d;
   logic [JOB_WIDTH-1:0]         job_q, job_d;
   logic [RESULT_WIDTH-1:0]      result_q, result_d;
   logic                         valid_q, valid_d;
   logic                         exh_q, exh_d;
   logic [RUN_LIMIT_WIDTH-1:0]   run_cnt_q, run_cnt_d;
   logic [RUN_LIMIT_WIDTH-1:0]   run_next;
   logic                         push;
   logic                         pop;
   logic                         limit;

   assign job_ready_out    = (count_q < DEPTH_C);
   assign push             = job_valid_in && job_ready_out && !flush_in;
   assign pop              = (state_q == S_IDLE) && (count_q != '0) && !flush_in;
   assign run_next         = run_cnt_q + 1'b1;
   assign limit            = &run_next;

   assign pool_job_out     = job_q;
   assign pool_reset_n_out = (state_q == S_RUN);
   assign result_out       = result_q;
   assign result_valid_out = valid_q;
   assign exhausted_out    = exh_q;
   assign busy_out         = (state_q != S_IDLE);
   assign queue_count_out  = count_q;

   always_comb begin
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_in) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) begin
            mem_d[tail_q] = job_in;
            tail_d        = tail_q + 1'b1;
         end
         if (pop) begin
            head_d = head_q + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      job_d     = job_q;
      result_d  = result_q;
      valid_d   = valid_q;
      exh_d     = exh_q;
      run_cnt_d = run_cnt_q;
      unique case (state_q)
         S_IDLE: begin
            exh_d = 1'b0;
            if (pop) begin
               job_d   = mem_q[head_q];
               state_d = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            state_d = S_RUN;
         end
         S_RUN: begin
            run_cnt_d = run_next;
            // success outranks the run limit when both land together
            if (pool_success_in) begin
               result_d = pool_nonce_in;
               exh_d    = 1'b0;
               valid_d  = 1'b1;
               state_d  = S_REPORT;
            end else if (limit) begin
               result_d = '0;
               exh_d    = 1'b1;
`ifdef POOL_JOB_SEQ_SKIP_EXHAUSTED_EN
               run_cnt_d = '0;
               state_d   = S_IDLE;
`else
               valid_d   = 1'b1;
               state_d   = S_REPORT;
`endif
            end
         end
         S_REPORT: begin
            if (result_ack_in) begin
               valid_d   = 1'b0;
               exh_d     = 1'b0;
               run_cnt_d = '0;
               state_d   = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (flush_in) begin
         state_d   = S_IDLE;
         valid_d   = 1'b0;
         exh_d     = 1'b0;
         run_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         mem_q     <= '{default: '0};
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         job_q     <= '0;
         result_q  <= '0;
         valid_q   <= 1'b0;
         exh_q     <= 1'b0;
         run_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         mem_q     <= mem_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         job_q     <= job_d;
         result_q  <= result_d;
         valid_q   <= valid_d;
         exh_q     <= exh_d;
         run_cnt_q <= run_cnt_d;
      end
   end

endmodule

// File: tb/tb_pool_job_sequencer.sv
// Directed bench for pool_job_sequencer with RUN_LIMIT_WIDTH = 4, QUEUE_DEPTH = 2.
module tb_pool_job_sequencer;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [359:0] job_in = '0;
   logic         job_valid_in = 1'b0;
   logic         job_ready_out;
   logic         flush_in = 1'b0;
   logic [359:0] pool_job_out;
   logic         pool_reset_n_out;
   logic         pool_success_in = 1'b0;
   logic [31:0]  pool_nonce_in = '0;
   logic [31:0]  result_out;
   logic         result_valid_out;
   logic         result_ack_in = 1'b0;
   logic         exhausted_out;
   logic         busy_out;
   logic [1:0]   queue_count_out;

   int total = 0;
   int bad = 0;

   logic [359:0] job_a, job_b, job_c, job_d;

   pool_job_sequencer #(
      .JOB_WIDTH(360), .RESULT_WIDTH(32), .QUEUE_DEPTH(2),
      .QUEUE_DEPTH_LOG2(1), .RUN_LIMIT_WIDTH(4)
   ) dut (
      .clk(clk), .reset(reset), .job_in(job_in),
      .job_valid_in(job_valid_in), .job_ready_out(job_ready_out),
      .flush_in(flush_in), .pool_job_out(pool_job_out),
      .pool_reset_n_out(pool_reset_n_out),
      .pool_success_in(pool_success_in), .pool_nonce_in(pool_nonce_in),
      .result_out(result_out), .result_valid_out(result_valid_out),
      .result_ack_in(result_ack_in), .exhausted_out(exhausted_out),
      .busy_out(busy_out), .queue_count_out(queue_count_out)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [359:0] obs,
                      input logic [359:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   initial begin
      job_a = {90{4'hA}};
      job_b = {90{4'hB}};
      job_c = {90{4'hC}};
      job_d = {90{4'hD}};

      // reset state
      step(2);
      chk("rst_ready", job_ready_out, 1);
      chk("rst_prn", pool_reset_n_out, 0);
      chk("rst_job", pool_job_out, 0);
      chk("rst_res", result_out, 0);
      chk("rst_valid", result_valid_out, 0);
      chk("rst_exh", exhausted_out, 0);
      chk("rst_busy", busy_out, 0);
      chk("rst_cnt", queue_count_out, 0);
      reset = 1'b0;
      step(1);

      // 1: success on 5th RUN cycle
      job_in = job_a; job_valid_in = 1'b1;
      step(1);
      job_valid_in = 1'b0;
      chk("s1_cnt1", queue_count_out, 1);
      chk("s1_idle", busy_out, 0);
      step(1);
      chk("s1_launch_busy", busy_out, 1);
      chk("s1_launch_prn", pool_reset_n_out, 0);
      chk("s1_launch_job", pool_job_out, job_a);
      chk("s1_launch_cnt", queue_count_out, 0);
      step(1);
      chk("s1_run_prn", pool_reset_n_out, 1);
      step(4);
      chk("s1_run5_valid", result_valid_out, 0);
      pool_success_in = 1'b1; pool_nonce_in = 32'h0000_1234;
      step(1);
      pool_success_in = 1'b0;
      chk("s1_valid", result_valid_out, 1);
      chk("s1_res", result_out, 32'h0000_1234);
      chk("s1_exh", exhausted_out, 0);
      chk("s1_rep_prn", pool_reset_n_out, 0);
      step(2);
      chk("s1_hold_valid", result_valid_out, 1);
      result_ack_in = 1'b1;
      step(1);
      result_ack_in = 1'b0;
      chk("s1_ack_valid", result_valid_out, 0);
      chk("s1_ack_busy", busy_out, 0);
      chk("s1_ack_prn", pool_reset_n_out, 0);

      // 2: run limit exhaustion after 15 RUN cycles
      job_in = job_b; job_valid_in = 1'b1;
      step(1);
      job_valid_in = 1'b0;
      step(2);
      chk("s2_run1_prn", pool_reset_n_out, 1);
      step(14);
      chk("s2_run15_prn", pool_reset_n_out, 1);
      chk("s2_run15_valid", result_valid_out, 0);
      step(1);
      chk("s2_exh", exhausted_out, 1);
      chk("s2_res", result_out, 0);
      chk("s2_prn", pool_reset_n_out, 0);
`ifdef POOL_JOB_SEQ_SKIP_EXHAUSTED_EN
      chk("s2_valid", result_valid_out, 0);
      chk("s2_busy", busy_out, 0);
      step(1);
      chk("s2_pulse_end", exhausted_out, 0);
      chk("s2_valid_after", result_valid_out, 0);
`else
      chk("s2_valid", result_valid_out, 1);
      chk("s2_busy", busy_out, 1);
      result_ack_in = 1'b1;
      step(1);
      result_ack_in = 1'b0;
      chk("s2_ack_valid", result_valid_out, 0);
      chk("s2_ack_busy", busy_out, 0);
`endif

      // 4: success coincides with the run limit
      job_in = job_c; job_valid_in = 1'b1;
      step(1);
      job_valid_in = 1'b0;
      step(2);
      step(14);
      chk("s4_run15_prn", pool_reset_n_out, 1);
      pool_success_in = 1'b1; pool_nonce_in = 32'hABCD_0F0F;
      step(1);
      pool_success_in = 1'b0;
      chk("s4_exh", exhausted_out, 0);
      chk("s4_res", result_out, 32'hABCD_0F0F);
      chk("s4_valid", result_valid_out, 1);
      result_ack_in = 1'b1;
      step(1);
      result_ack_in = 1'b0;

      // 3: back-to-back pushes, full queue refuses
      job_in = job_a; job_valid_in = 1'b1;
      step(1);
      chk("s3_cnt_a", queue_count_out, 1);
      job_in = job_b;
      step(1);
      chk("s3_cnt_b", queue_count_out, 1);
      chk("s3_job_a", pool_job_out, job_a);
      job_in = job_c;
      step(1);
      chk("s3_cnt_c", queue_count_out, 2);
      chk("s3_full_ready", job_ready_out, 0);
      chk("s3_run", pool_reset_n_out, 1);
      job_in = job_d;
      pool_success_in = 1'b1; pool_nonce_in = 32'h0000_0055;
      step(1);
      pool_success_in = 1'b0;
      job_valid_in = 1'b0;
      chk("s3_refuse_cnt", queue_count_out, 2);
      chk("s3_res", result_out, 32'h0000_0055);
      result_ack_in = 1'b1;
      step(1);
      result_ack_in = 1'b0;
      chk("s3_ack_busy", busy_out, 0);
      step(1);
      chk("s3_job_b", pool_job_out, job_b);
      chk("s3_pop_cnt", queue_count_out, 1);
      chk("s3_pop_ready", job_ready_out, 1);
      step(1);
      chk("s3_b_run", pool_reset_n_out, 1);

      // 5: flush mid-RUN with C queued, push in flush cycle dropped
      flush_in = 1'b1; job_in = job_d; job_valid_in = 1'b1;
      step(1);
      flush_in = 1'b0; job_valid_in = 1'b0;
      chk("s5_busy", busy_out, 0);
      chk("s5_cnt", queue_count_out, 0);
      chk("s5_prn", pool_reset_n_out, 0);
      chk("s5_valid", result_valid_out, 0);
      chk("s5_ready", job_ready_out, 1);
      result_ack_in = 1'b1;
      step(1);
      result_ack_in = 1'b0;
      chk("s5_ack_valid", result_valid_out, 0);
      chk("s5_ack_busy", busy_out, 0);
      chk("s5_ack_cnt", queue_count_out, 0);

      // 6: reset during REPORT
      job_in = job_b; job_valid_in = 1'b1;
      step(1);
      job_valid_in = 1'b0;
      step(2);
      pool_success_in = 1'b1; pool_nonce_in = 32'h0000_0777;
      step(1);
      pool_success_in = 1'b0;
      chk("s6_valid", result_valid_out, 1);
      reset = 1'b1;
      step(1);
      chk("s6_valid_rst", result_valid_out, 0);
      chk("s6_res", result_out, 0);
      chk("s6_job", pool_job_out, 0);
      chk("s6_busy", busy_out, 0);
      chk("s6_prn", pool_reset_n_out, 0);
      chk("s6_ready", job_ready_out, 1);
      chk("s6_cnt", queue_count_out, 0);
      chk("s6_exh", exhausted_out, 0);
      reset = 1'b0;
      step(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
